// File: rtl/bj_predict_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bj_predict_resolve_unit
//  Purpose  : Resolves RV32IM branch/jump conditions in EX and drives PC_SEL.
//             A direct-mapped table of saturating counters predicts the
//             direction for the IF stage. Mispredictions are flagged against
//             the prediction carried down the pipeline, and saturating
//             branch/mispredict performance counters are maintained.
//  Ports    : CLK, RESET          - clock, synchronous active-high reset
//             IF_PC / PRED_TAKEN  - fetch-side lookup and prediction
//             EX_VALID, EX_STALL  - EX qualifiers (stall freezes all state)
//             EX_PC, BRANCH_JUMP  - EX instruction PC and op code
//             DATA1, DATA2        - rs1 / rs2 operands
//             EX_PRED_TAKEN       - prediction made in IF for this op
//             PC_SEL, MISPREDICT  - combinational resolution results
//             BRANCH_CNT          - resolved conditional branch count
//             MISPRED_CNT         - mispredicted conditional branch count
//  Revision : 1.0 - initial release
// ============================================================================
module bj_predict_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_BITS    = 2,
  parameter int PERF_BITS   = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [XLEN-1:0]      IF_PC,
  output logic                 PRED_TAKEN,
  input  logic                 EX_VALID,
  input  logic                 EX_STALL,
  input  logic [XLEN-1:0]      EX_PC,
  input  logic [3:0]           BRANCH_JUMP,
  input  logic [XLEN-1:0]      DATA1,
  input  logic [XLEN-1:0]      DATA2,
  input  logic                 EX_PRED_TAKEN,
  output logic                 PC_SEL,
  output logic                 MISPREDICT,
  output logic [PERF_BITS-1:0] BRANCH_CNT,
  output logic [PERF_BITS-1:0] MISPRED_CNT
);

  localparam int c_idx = $clog2(BHT_ENTRIES);
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] c_ctr_init = {1'b0, {(CTR_BITS-1){1'b1}}};

  // --------------------------------------------------------------------------
  // Condition resolution
  // --------------------------------------------------------------------------
  logic [2:0] w_funct3;
  logic       w_is_cond;
  logic       w_is_jump;
  logic       w_cond_legal;
  logic       w_cond_taken;

  assign w_funct3     = BRANCH_JUMP[2:0];
  assign w_is_cond    = BRANCH_JUMP[3];
  assign w_is_jump    = (BRANCH_JUMP == 4'b0001);
  // funct3 010/011 have no branch meaning.
  assign w_cond_legal = w_is_cond && (w_funct3[2:1] != 2'b01);

  always_comb begin
    w_cond_taken = 1'b0;
    // Operands only looked at for conditional ops so X on DATA cannot leak.
    if (w_is_cond) begin
      case (w_funct3)
        3'b000:  w_cond_taken = (DATA1 == DATA2);
        3'b001:  w_cond_taken = (DATA1 != DATA2);
        3'b100:  w_cond_taken = ($signed(DATA1) < $signed(DATA2));
        3'b101:  w_cond_taken = !($signed(DATA1) < $signed(DATA2));
        3'b110:  w_cond_taken = (DATA1 < DATA2);
        3'b111:  w_cond_taken = !(DATA1 < DATA2);
        default: w_cond_taken = 1'b0;
      endcase
    end
  end

  logic w_update;

  assign PC_SEL     = EX_VALID && (w_is_jump || (w_is_cond && w_cond_taken));
  // Jumps are excluded; target prediction for them lives elsewhere.
  assign MISPREDICT = EX_VALID && w_cond_legal && (PC_SEL != EX_PRED_TAKEN);
  assign w_update   = EX_VALID && !EX_STALL && w_cond_legal;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  logic [c_idx-1:0]    w_if_idx;
  logic [c_idx-1:0]    w_ex_idx;
  logic [CTR_BITS-1:0] w_ctr_cur;
  logic [CTR_BITS-1:0] w_ctr_next;
  logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CTR_BITS-1:0] bht_d [BHT_ENTRIES];

  assign w_if_idx  = IF_PC[c_idx+1:2];
  assign w_ex_idx  = EX_PC[c_idx+1:2];
  // Lookup reads the stored table only: a same-cycle update is not bypassed.
  assign PRED_TAKEN = bht_q[w_if_idx][CTR_BITS-1];
  assign w_ctr_cur  = bht_q[w_ex_idx];

  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (PC_SEL) begin
      if (w_ctr_cur != {CTR_BITS{1'b1}}) w_ctr_next = w_ctr_cur + CTR_BITS'(1);
    end else begin
      if (w_ctr_cur != {CTR_BITS{1'b0}}) w_ctr_next = w_ctr_cur - CTR_BITS'(1);
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (w_update) bht_d[w_ex_idx] = w_ctr_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= c_ctr_init;
    end else begin
      bht_q <= bht_d;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [PERF_BITS-1:0] branch_cnt_q, branch_cnt_d;
  logic [PERF_BITS-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (w_update && (branch_cnt_q != {PERF_BITS{1'b1}}))
      branch_cnt_d = branch_cnt_q + PERF_BITS'(1);
    if (w_update && MISPREDICT && (mispred_cnt_q != {PERF_BITS{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + PERF_BITS'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BRANCH_CNT  = branch_cnt_q;
  assign MISPRED_CNT = mispred_cnt_q;

  // PC bits outside the index field play no part in prediction.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_PC[XLEN-1:c_idx+2], IF_PC[1:0],
                            EX_PC[XLEN-1:c_idx+2], EX_PC[1:0]};

endmodule
`default_nettype wire
